arbtr_ctrl_mc: RTL and testbench

- Parametrised, multi-buffer successor to the single-buffer arbitration controller for the CAN XL/CAN SEC controller.
- Selects the highest-priority pending TX buffer at start of frame and tracks the node role per frame: idle/integrating, arbitrating transmitter, transmitter after winning, or receiver.
- Records the bit position where arbitration was lost and counts retransmission attempts, with an optional abort limit.
- Drives the XL data-phase speed status for the bit-timing logic.

---
 rtl/arbtr_ctrl_mc.sv | 226 ++++++++++++++++++++++
 tb/tb_arbtr_ctrl_mc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/arbtr_ctrl_mc.sv
// Multi-buffer arbitration controller for the CAN XL / CAN SEC protocol core.
// At start of frame it picks the pending TX buffer with the lowest priority
// key. It then tracks the node role for the frame (idle, arbitrating, winning
// transmitter, receiver), records where arbitration was lost, counts
// retransmission attempts with an optional abort limit, and drives the XL
// data-phase speed flag for the bit-timing logic.
module arbtr_ctrl_mc #(
  parameter int NUM_TXB = 4,
  parameter int ID_W    = 29,
  parameter int POS_W   = 6,
  parameter int RETX_W  = 4,
  localparam int SEL_W  = (NUM_TXB > 1) ? $clog2(NUM_TXB) : 1
) (
  input  logic                    osc_clk,
  input  logic                    g_rst,
  input  logic                    sampling_pt,
  input  logic                    arbtr_fld,
  input  logic                    can_bus_out,
  input  logic                    can_bus_in,
  input  logic                    bit_destf_intl,
  input  logic                    dt_rm_frm_tx,
  input  logic                    bt_ack_err_pre,
  input  logic                    rcvd_lst_bit_ifs,
  input  logic                    txed_lst_bit_ifs,
  input  logic                    ovld_err_tx_cmp,
  input  logic                    act_err_frm_tx,
  input  logic                    psv_err_frm_tx,
  input  logic                    adh,
  input  logic                    dah,
  input  logic [NUM_TXB-1:0]      tx_req,
  input  logic [NUM_TXB*ID_W-1:0] tx_prio,
  input  logic [RETX_W-1:0]       retx_lim,
  output logic                    arbtr_sts,
  output logic                    msg_due_tx,
  output logic                    speed_status,
  output logic [SEL_W-1:0]        tx_sel,
  output logic                    tx_sel_vld,
  output logic                    arb_lost,
  output logic [POS_W-1:0]        arb_lost_pos,
  output logic [NUM_TXB-1:0]      tx_done,
  output logic [NUM_TXB-1:0]      tx_abort,
  output logic [RETX_W-1:0]       retx_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_TX   = 2'd2,
    ST_RX   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [RETX_W-1:0]  retx_q, retx_d;
  logic [RETX_W-1:0]  retx_inc;
  logic               retx_bump;
  logic               lost_q, lost_d;
  logic [POS_W-1:0]   lost_pos_q, lost_pos_d;
  logic [NUM_TXB-1:0] done_q, done_d;
  logic [NUM_TXB-1:0] abort_q, abort_d;
  logic               speed_q, speed_d;
  logic               fld_q;
  logic               err_q;

  logic [SEL_W-1:0]   best_idx;
  logic [ID_W-1:0]    best_key;
  logic               any_req;

  logic err_any, frame_end, start, err_rise, strobe, loss, fld_fall;

  function automatic logic [POS_W-1:0] sat_inc_pos(input logic [POS_W-1:0] v);
    return (&v) ? v : v + POS_W'(1);
  endfunction

  function automatic logic [RETX_W-1:0] sat_inc_retx(input logic [RETX_W-1:0] v);
    return (&v) ? v : v + RETX_W'(1);
  endfunction

  function automatic logic [NUM_TXB-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_TXB-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_TXB; i++) begin
      if (s == SEL_W'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  assign err_any   = act_err_frm_tx | psv_err_frm_tx;
  assign frame_end = (rcvd_lst_bit_ifs | txed_lst_bit_ifs) & ~err_any;
  assign start     = (bit_destf_intl & ~dt_rm_frm_tx) | (bt_ack_err_pre & (|tx_req));
  assign err_rise  = err_any & ~err_q;
  assign strobe    = sampling_pt & arbtr_fld;
  assign loss      = strobe & can_bus_out & ~can_bus_in;
  assign fld_fall  = fld_q & ~arbtr_fld;

  // Lowest key among requesting buffers; strict compare keeps the lowest index on ties
  always_comb begin
    best_idx = '0;
    best_key = '0;
    any_req  = 1'b0;
    for (int i = 0; i < NUM_TXB; i++) begin
      if (tx_req[i] && (!any_req || (tx_prio[i*ID_W +: ID_W] < best_key))) begin
        any_req  = 1'b1;
        best_idx = SEL_W'(i);
        best_key = tx_prio[i*ID_W +: ID_W];
      end
    end
  end

  // Next-state and registered-output logic; event priority ovld > frame end > start > loss > fld fall
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pos_d      = pos_q;
    retx_d     = retx_q;
    retx_inc   = sat_inc_retx(retx_q);
    retx_bump  = 1'b0;
    lost_d     = 1'b0;
    lost_pos_d = lost_pos_q;
    done_d     = '0;
    abort_d    = '0;
    speed_d    = speed_q;

    if (ovld_err_tx_cmp) begin
      state_d = ST_IDLE;
    end else if (frame_end) begin
      state_d = ST_IDLE;
      if (state_q == ST_TX) begin
        done_d = sel_onehot(sel_q);
        retx_d = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pos_d = '0;
            if (any_req) begin
              state_d = ST_ARB;
              sel_d   = best_idx;
              // A different buffer starts its own attempt count
              if (best_idx != sel_q) retx_d = '0;
            end else begin
              state_d = ST_RX;
            end
          end
        end
        ST_ARB: begin
          if (strobe) pos_d = sat_inc_pos(pos_q);
          // Dominant-over-recessive is a loss; the reverse is a bit error handled elsewhere
          if (loss) begin
            state_d    = ST_RX;
            lost_d     = 1'b1;
            lost_pos_d = pos_q;
            retx_bump  = 1'b1;
          end else if (fld_fall) begin
            state_d = ST_TX;
          end
        end
        default: ;
      endcase
    end

    if (err_rise && ((state_q == ST_ARB) || (state_q == ST_TX))) retx_bump = 1'b1;

    if (retx_bump) begin
      if ((retx_lim != '0) && (retx_inc >= retx_lim)) begin
        abort_d = sel_onehot(sel_q);
        retx_d  = '0;
      end else begin
        retx_d  = retx_inc;
      end
    end

    // Any error frame or overload completion falls back to the nominal rate
    if (ovld_err_tx_cmp || err_rise) speed_d = 1'b0;
    else if (adh)                    speed_d = 1'b1;
    else if (dah)                    speed_d = 1'b0;
  end

  // FSM state register
  always_ff @(posedge osc_clk) begin
    if (g_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Selection, counters, pulses and edge-detect history
  always_ff @(posedge osc_clk) begin
    if (g_rst) begin
      sel_q      <= '0;
      pos_q      <= '0;
      retx_q     <= '0;
      lost_q     <= 1'b0;
      lost_pos_q <= '0;
      done_q     <= '0;
      abort_q    <= '0;
      speed_q    <= 1'b0;
      fld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      pos_q      <= pos_d;
      retx_q     <= retx_d;
      lost_q     <= lost_d;
      lost_pos_q <= lost_pos_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      speed_q    <= speed_d;
      fld_q      <= arbtr_fld;
      err_q      <= err_any;
    end
  end

  assign arbtr_sts    = (state_q == ST_IDLE);
  assign msg_due_tx   = (state_q == ST_ARB) || (state_q == ST_TX);
  assign tx_sel_vld   = (state_q == ST_ARB) || (state_q == ST_TX);
  assign tx_sel       = sel_q;
  assign speed_status = speed_q;
  assign arb_lost     = lost_q;
  assign arb_lost_pos = lost_pos_q;
  assign tx_done      = done_q;
  assign tx_abort     = abort_q;
  assign retx_cnt     = retx_q;

endmodule

// File: tb/tb_arbtr_ctrl_mc.sv
// Directed bench for arbtr_ctrl_mc with hand-computed expected values.
module tb_arbtr_ctrl_mc;

  localparam int NUM_TXB = 4;
  localparam int ID_W    = 29;
  localparam int POS_W   = 6;
  localparam int RETX_W  = 4;

  logic                    osc_clk;
  logic                    g_rst;
  logic                    sampling_pt, arbtr_fld, can_bus_out, can_bus_in;
  logic                    bit_destf_intl, dt_rm_frm_tx, bt_ack_err_pre;
  logic                    rcvd_lst_bit_ifs, txed_lst_bit_ifs, ovld_err_tx_cmp;
  logic                    act_err_frm_tx, psv_err_frm_tx, adh, dah;
  logic [NUM_TXB-1:0]      tx_req;
  logic [NUM_TXB*ID_W-1:0] tx_prio;
  logic [RETX_W-1:0]       retx_lim;
  logic                    arbtr_sts, msg_due_tx, speed_status, tx_sel_vld, arb_lost;
  logic [1:0]              tx_sel;
  logic [POS_W-1:0]        arb_lost_pos;
  logic [NUM_TXB-1:0]      tx_done, tx_abort;
  logic [RETX_W-1:0]       retx_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [NUM_TXB-1:0] abort_seen;

  arbtr_ctrl_mc #(
    .NUM_TXB(NUM_TXB), .ID_W(ID_W), .POS_W(POS_W), .RETX_W(RETX_W)
  ) dut (
    .osc_clk(osc_clk), .g_rst(g_rst), .sampling_pt(sampling_pt), .arbtr_fld(arbtr_fld),
    .can_bus_out(can_bus_out), .can_bus_in(can_bus_in), .bit_destf_intl(bit_destf_intl),
    .dt_rm_frm_tx(dt_rm_frm_tx), .bt_ack_err_pre(bt_ack_err_pre),
    .rcvd_lst_bit_ifs(rcvd_lst_bit_ifs), .txed_lst_bit_ifs(txed_lst_bit_ifs),
    .ovld_err_tx_cmp(ovld_err_tx_cmp), .act_err_frm_tx(act_err_frm_tx),
    .psv_err_frm_tx(psv_err_frm_tx), .adh(adh), .dah(dah), .tx_req(tx_req),
    .tx_prio(tx_prio), .retx_lim(retx_lim), .arbtr_sts(arbtr_sts), .msg_due_tx(msg_due_tx),
    .speed_status(speed_status), .tx_sel(tx_sel), .tx_sel_vld(tx_sel_vld),
    .arb_lost(arb_lost), .arb_lost_pos(arb_lost_pos), .tx_done(tx_done),
    .tx_abort(tx_abort), .retx_cnt(retx_cnt)
  );

  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_prio(input int idx, input logic [ID_W-1:0] key);
    tx_prio[idx*ID_W +: ID_W] = key;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_arbtr_sts"},  32'(arbtr_sts),    32'h1);
    chk({tag, "_msg_due_tx"}, 32'(msg_due_tx),   32'h0);
    chk({tag, "_speed"},      32'(speed_status), 32'h0);
    chk({tag, "_tx_sel"},     32'(tx_sel),       32'h0);
    chk({tag, "_tx_sel_vld"}, 32'(tx_sel_vld),   32'h0);
    chk({tag, "_arb_lost"},   32'(arb_lost),     32'h0);
    chk({tag, "_lost_pos"},   32'(arb_lost_pos), 32'h0);
    chk({tag, "_tx_done"},    32'(tx_done),      32'h0);
    chk({tag, "_tx_abort"},   32'(tx_abort),     32'h0);
    chk({tag, "_retx_cnt"},   32'(retx_cnt),     32'h0);
  endtask

  initial begin
    g_rst = 1'b1;
    sampling_pt = 0; arbtr_fld = 0; can_bus_out = 1; can_bus_in = 1;
    bit_destf_intl = 0; dt_rm_frm_tx = 0; bt_ack_err_pre = 0;
    rcvd_lst_bit_ifs = 0; txed_lst_bit_ifs = 0; ovld_err_tx_cmp = 0;
    act_err_frm_tx = 0; psv_err_frm_tx = 0; adh = 0; dah = 0;
    tx_req = '0; tx_prio = '0; retx_lim = '0;
    abort_seen = '0;

    // Reset
    tick(); tick();
    chk_reset_state("rst");
    g_rst = 1'b0;

    // Priority select: buffer 3 (0x0FF) beats buffer 1 (0x120)
    tx_req = 4'b1010; set_prio(1, 29'h120); set_prio(3, 29'h0FF);
    bit_destf_intl = 1; tick(); bit_destf_intl = 0;
    chk("sel_tx_sel",     32'(tx_sel),     32'd3);
    chk("sel_vld",        32'(tx_sel_vld), 32'h1);
    chk("sel_arbtr_sts",  32'(arbtr_sts),  32'h0);
    chk("sel_msg_due_tx", 32'(msg_due_tx), 32'h1);

    // Win arbitration, then finish frame as transmitter
    arbtr_fld = 1; tick();
    arbtr_fld = 0; tick();
    chk("tx_msg_due_tx", 32'(msg_due_tx), 32'h1);
    txed_lst_bit_ifs = 1; tick(); txed_lst_bit_ifs = 0;
    chk("done_tx_done",   32'(tx_done),    32'b1000);
    chk("done_arbtr_sts", 32'(arbtr_sts),  32'h1);
    chk("done_retx",      32'(retx_cnt),   32'h0);
    chk("done_vld",       32'(tx_sel_vld), 32'h0);
    tick();
    chk("done_pulse_end", 32'(tx_done),    32'h0);

    // Tie on equal keys resolves to the lowest index
    tx_req = 4'b0101; set_prio(0, 29'h55); set_prio(2, 29'h55);
    bt_ack_err_pre = 1; tick(); bt_ack_err_pre = 0;
    chk("tie_tx_sel", 32'(tx_sel),     32'd0);
    chk("tie_vld",    32'(tx_sel_vld), 32'h1);

    // Seven matching strobes (one a bit error, ignored), then lose on the eighth
    arbtr_fld = 1; sampling_pt = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin can_bus_out = 0; can_bus_in = 1; end
      else        begin can_bus_out = 1; can_bus_in = 1; end
      tick();
    end
    chk("biterr_still_arb", 32'(msg_due_tx), 32'h1);
    can_bus_out = 1; can_bus_in = 0; tick();
    sampling_pt = 0; can_bus_in = 1;
    chk("loss_pulse",      32'(arb_lost),     32'h1);
    chk("loss_pos",        32'(arb_lost_pos), 32'd7);
    chk("loss_retx",       32'(retx_cnt),     32'd1);
    chk("loss_msg_due_tx", 32'(msg_due_tx),   32'h0);
    chk("loss_arbtr_sts",  32'(arbtr_sts),    32'h0);
    arbtr_fld = 0; tick();
    chk("loss_pulse_end",  32'(arb_lost),     32'h0);
    chk("loss_pos_held",   32'(arb_lost_pos), 32'd7);
    rcvd_lst_bit_ifs = 1; tick(); rcvd_lst_bit_ifs = 0;
    chk("rx_end_idle",     32'(arbtr_sts),    32'h1);
    chk("rx_end_retx",     32'(retx_cnt),     32'd1);
    chk("rx_end_no_done",  32'(tx_done),      32'h0);

    // Reselect buffer 1 (different from 0): attempt count restarts
    retx_lim = 4'd3; tx_req = 4'b0010;
    bit_destf_intl = 1; tick(); bit_destf_intl = 0;
    chk("resel_tx_sel", 32'(tx_sel),   32'd1);
    chk("resel_retx",   32'(retx_cnt), 32'd0);

    // Speed flag: adh sets, adh wins over dah, error frame start clears
    adh = 1; tick();
    chk("spd_adh", 32'(speed_status), 32'h1);
    dah = 1; tick(); adh = 0; dah = 0;
    chk("spd_adh_dah", 32'(speed_status), 32'h1);

    // Three error frames on buffer 1 with limit 3
    for (int n = 1; n <= 3; n++) begin
      if (n > 1) begin
        bit_destf_intl = 1; tick(); bit_destf_intl = 0;
        chk("err_restart_sel", 32'(tx_sel), 32'd1);
      end
      act_err_frm_tx = 1; tick();
      if (n == 1) chk("spd_err_clear", 32'(speed_status), 32'h0);
      if (n < 3) begin
        chk("err_retx",       32'(retx_cnt),   32'(n));
        chk("err_no_abort",   32'(tx_abort),   32'h0);
        chk("err_state_kept", 32'(msg_due_tx), 32'h1);
        act_err_frm_tx = 0; ovld_err_tx_cmp = 1; tick(); ovld_err_tx_cmp = 0;
        chk("ovld_idle", 32'(arbtr_sts), 32'h1);
      end else begin
        chk("abort_pulse", 32'(tx_abort), 32'b0010);
        chk("abort_retx",  32'(retx_cnt), 32'd0);
      end
    end
    act_err_frm_tx = 0; tick();
    chk("abort_pulse_end", 32'(tx_abort), 32'h0);

    // Unlimited: sixteen error-frame starts saturate at 15 with no abort
    retx_lim = 4'd0;
    for (int n = 0; n < 16; n++) begin
      psv_err_frm_tx = 1; tick();
      abort_seen = abort_seen | tx_abort;
      psv_err_frm_tx = 0; tick();
    end
    chk("sat_retx",     32'(retx_cnt),   32'd15);
    chk("sat_no_abort", 32'(abort_seen), 32'h0);

    // Move to TX with speed raised, then exercise dah alone and reset mid-frame
    adh = 1; tick(); adh = 0;
    arbtr_fld = 1; tick();
    arbtr_fld = 0; tick();
    chk("pre_rst_msg_due_tx", 32'(msg_due_tx),   32'h1);
    dah = 1; tick(); dah = 0;
    chk("spd_dah", 32'(speed_status), 32'h0);
    adh = 1; tick(); adh = 0;
    chk("pre_rst_speed", 32'(speed_status), 32'h1);
    g_rst = 1; tick();
    chk_reset_state("midrst");
    g_rst = 0;

    // Start blocked by an ongoing frame, then start with no request goes to RX
    tx_req = '0; dt_rm_frm_tx = 1; bit_destf_intl = 1; tick();
    chk("blocked_idle", 32'(arbtr_sts), 32'h1);
    dt_rm_frm_tx = 0; tick(); bit_destf_intl = 0;
    chk("rx_arbtr_sts",  32'(arbtr_sts),  32'h0);
    chk("rx_msg_due_tx", 32'(msg_due_tx), 32'h0);
    chk("rx_vld",        32'(tx_sel_vld), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
